// File: rtl/imm_enc_pkg.sv
// -----------------------------------------------------------------------------
// imm_enc_pkg : shared types and opcode constants for the immediate encoder
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package imm_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } instr_fields_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // True when v[31:lsb] is a pure sign extension (all zeros or all ones).
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] s;
    s = $signed(v) >>> lsb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_pack.sv
// -----------------------------------------------------------------------------
// imm_pack : combinational RV32I field packer with immediate range check
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module imm_pack
  import imm_enc_pkg::*;
(
  input  instr_fields_t f_i,
  output logic [31:0]   instr_o,
  output logic          err_o
);

  always_comb begin
    instr_o = '0;
    err_o   = 1'b0;
    case (f_i.fmt)
      FMT_R: begin
        instr_o = {f_i.funct7, f_i.rs2, f_i.rs1, f_i.funct3, f_i.rd, f_i.opcode};
      end
      FMT_I: begin
        instr_o = {f_i.imm[11:0], f_i.rs1, f_i.funct3, f_i.rd, f_i.opcode};
        err_o   = !fits_signed(f_i.imm, 11);
      end
      FMT_S: begin
        instr_o = {f_i.imm[11:5], f_i.rs2, f_i.rs1, f_i.funct3, f_i.imm[4:0], f_i.opcode};
        err_o   = !fits_signed(f_i.imm, 11);
      end
      FMT_B: begin
        instr_o = {f_i.imm[12], f_i.imm[10:5], f_i.rs2, f_i.rs1, f_i.funct3,
                   f_i.imm[4:1], f_i.imm[11], f_i.opcode};
        err_o   = !fits_signed(f_i.imm, 12) || f_i.imm[0];
      end
      FMT_U: begin
        instr_o = {f_i.imm[31:12], f_i.rd, f_i.opcode};
        err_o   = |f_i.imm[11:0];
      end
      FMT_J: begin
        instr_o = {f_i.imm[20], f_i.imm[10:1], f_i.imm[11], f_i.imm[19:12],
                   f_i.rd, f_i.opcode};
        err_o   = !fits_signed(f_i.imm, 20) || f_i.imm[0];
      end
      default: begin
        instr_o = '0;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder : 2-stage valid/ready RV32I instruction encoder with counters
// Optional: define IMM_ENCODER_ERR_CNT_EN to build the o_cnt_err counter.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_fmt,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [31:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_instr,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cnt_instr,
  output logic [CNT_W-1:0] o_cnt_err
);

  instr_fields_t    req;
  instr_fields_t    s1_fields_q;
  logic             s1_valid_q;
  logic             s2_valid_q;
  logic [31:0]      instr_q;
  logic             err_q;
  logic [31:0]      pack_instr;
  logic             pack_err;
  logic             s1_adv;
  logic             s2_adv;
  logic             hs;
  logic [CNT_W-1:0] cnt_instr_q;
  logic [CNT_W-1:0] cnt_instr_d;

  always_comb begin
    req        = '0;
    req.fmt    = i_fmt;
    req.opcode = i_opcode;
    req.funct3 = i_funct3;
    req.funct7 = i_funct7;
    req.rd     = i_rd;
    req.rs1    = i_rs1;
    req.rs2    = i_rs2;
    req.imm    = i_imm;
  end

  // Backpressure ripples combinationally from i_ready to o_ready.
  assign s2_adv  = !s2_valid_q || i_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign o_ready = s1_adv;
  assign hs      = s2_valid_q && i_ready;

  imm_pack u_pack (
    .f_i     (s1_fields_q),
    .instr_o (pack_instr),
    .err_o   (pack_err)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_fields_q <= '0;
      instr_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= i_valid;
        if (i_valid) s1_fields_q <= req;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          instr_q <= pack_instr;
          err_q   <= pack_err;
        end
      end
    end
  end

  assign o_valid = s2_valid_q;
  assign o_instr = instr_q;
  assign o_err   = err_q;

  assign cnt_instr_d = (hs && !(&cnt_instr_q)) ? cnt_instr_q + CNT_W'(1) : cnt_instr_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_instr_q <= '0;
    else          cnt_instr_q <= cnt_instr_d;
  end

  assign o_cnt_instr = cnt_instr_q;

`ifdef IMM_ENCODER_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_err_q;
  logic [CNT_W-1:0] cnt_err_d;

  assign cnt_err_d = (hs && err_q && !(&cnt_err_q)) ? cnt_err_q + CNT_W'(1) : cnt_err_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_err_q <= '0;
    else          cnt_err_q <= cnt_err_d;
  end

  assign o_cnt_err = cnt_err_q;
`else
  assign o_cnt_err = '0;
`endif

endmodule

`default_nettype wire
